// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with a two-entry skid buffer.
// Optional stall-cycle counter port stall_cnt enabled by EX_MEM_STALL_CNT_EN.
module ex_mem_pipe #(
    parameter int WB_W   = 2,
    parameter int M_W    = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   WB_in,
    input  logic [M_W-1:0]    M_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] aluResult_in,
    input  logic [DATA_W-1:0] rt_in,
    input  logic              zero_in,
    input  logic [REG_W-1:0]  writebackDestination_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   WB_out,
    output logic [M_W-1:0]    M_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] aluResult_out,
    output logic [DATA_W-1:0] rt_out,
    output logic              zero_out,
    output logic [REG_W-1:0]  writebackDestination_out
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam int EW = WB_W + M_W + 3 * DATA_W + 1 + REG_W;

    logic [EW-1:0] in_e, o_q, o_d, s_q, s_d;
    logic          ov_q, ov_d, sv_q, sv_d;
    logic          in_xfer, out_xfer;

    assign in_e = {WB_in, M_in, pc_in, aluResult_in, rt_in, zero_in, writebackDestination_in};
    assign {WB_out, M_out, pc_out, aluResult_out, rt_out, zero_out, writebackDestination_out} = o_q;
    assign in_ready  = !sv_q;
    assign out_valid = ov_q;
    assign in_xfer   = in_valid && !sv_q;
    assign out_xfer  = ov_q && out_ready;

    // Output register is cleared whenever it empties so WB/M read as zero.
    always_comb begin
        o_d  = o_q;
        s_d  = s_q;
        ov_d = ov_q;
        sv_d = sv_q;
        if (flush) begin
            o_d  = '0;
            ov_d = 1'b0;
            sv_d = 1'b0;
        end else if (sv_q && out_xfer) begin
            o_d  = s_q;
            sv_d = 1'b0;
        end else if (in_xfer && (!ov_q || out_xfer)) begin
            o_d  = in_e;
            ov_d = 1'b1;
        end else if (in_xfer) begin
            s_d  = in_e;
            sv_d = 1'b1;
        end else if (out_xfer) begin
            o_d  = '0;
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q  <= '0;
            s_q  <= '0;
            ov_q <= 1'b0;
            sv_q <= 1'b0;
        end else begin
            o_q  <= o_d;
            s_q  <= s_d;
            ov_q <= ov_d;
            sv_q <= sv_d;
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_q <= 16'd0;
        else if (ov_q && !out_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`endif
endmodule
